icache_refill_ctrl: RTL and testbench

//  Sequences instruction main memory during an I-cache miss: latches the missing line address, reads

---
 rtl/icache_refill_if.sv | 48 ++++
 rtl/icache_refill_ctrl.sv | 125 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_if.sv
// I-cache refill bus bundle: fetch request, main memory port,
// and the line-buffer write stream with status outputs.
interface icache_refill_if #(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
);
  localparam int IW = $clog2(LINE_WORDS);

  logic [31:0]      pc;
  logic             miss_cache;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_rdata;
  logic             refill_we;
  logic [IW-1:0]    refill_idx;
  logic [31:0]      refill_data;
  logic [31:0]      refill_base;
  logic             refill_done;
  logic             stall;
  logic [CNT_W-1:0] refill_count;

  modport slave (
    input  pc,
    input  miss_cache,
    input  mem_rdata,
    output mem_addr,
    output refill_we,
    output refill_idx,
    output refill_data,
    output refill_base,
    output refill_done,
    output stall,
    output refill_count
  );

  modport master (
    output pc,
    output miss_cache,
    output mem_rdata,
    input  mem_addr,
    input  refill_we,
    input  refill_idx,
    input  refill_data,
    input  refill_base,
    input  refill_done,
    input  stall,
    input  refill_count
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache miss refill sequencer: latches the line base, reads
// LINE_WORDS words from main memory and streams them to the line buffer.
module icache_refill_ctrl #(
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  icache_refill_if.slave  bus
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [WW-1:0] LAT_LAST  = WW'(MEM_LATENCY - 1);
  localparam logic [IW-1:0] WORD_LAST = IW'(LINE_WORDS - 1);
  localparam logic [31:0]   LINE_MASK = ~(32'(4 * LINE_WORDS) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_word;
  logic [WW-1:0]    r_wait;
  logic [31:0]      r_base;
  logic             r_we;
  logic [IW-1:0]    r_idx;
  logic [31:0]      r_data;
  logic             r_done;
  logic [CNT_W-1:0] r_count;

  logic             w_capture;
  logic             w_last;
  logic [31:0]      w_mem_addr;

  assign w_capture = (r_state == S_FETCH) && (r_wait == LAT_LAST);
  assign w_last    = w_capture && (r_word == WORD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.miss_cache) w_next = S_FETCH;
      S_FETCH: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory address: pass pc while idle, walk the line while refilling
  always_comb begin
    w_mem_addr = bus.pc;
    unique case (r_state)
      S_IDLE:  w_mem_addr = bus.pc;
      S_FETCH: w_mem_addr = r_base + (32'(r_word) << 2);
      S_DONE:  w_mem_addr = r_base;
      default: w_mem_addr = bus.pc;
    endcase
  end

  // Refill datapath: line latch, word/wait counters, write strobe, stats
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word  <= '0;
      r_wait  <= '0;
      r_base  <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.miss_cache) begin
            r_base <= bus.pc & LINE_MASK;
            r_word <= '0;
            r_wait <= '0;
          end
        end
        S_FETCH: begin
          if (w_capture) begin
            r_data <= bus.mem_rdata;
            r_idx  <= r_word;
            r_we   <= 1'b1;
            r_wait <= '0;
            r_word <= r_word + IW'(1);
            r_done <= (r_word == WORD_LAST);
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_DONE: begin
          if (r_count != '1) r_count <= r_count + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr     = w_mem_addr;
  assign bus.refill_we    = r_we;
  assign bus.refill_idx   = r_idx;
  assign bus.refill_data  = r_data;
  assign bus.refill_base  = r_base;
  assign bus.refill_done  = r_done;
  assign bus.stall        = bus.miss_cache | (r_state != S_IDLE);
  assign bus.refill_count = r_count;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: two instances (latency 1 / 3)
// share fetch stimulus; a line-level model feeds a write scoreboard.
module tb_icache_refill_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        miss = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  icache_refill_if #(.LINE_WORDS(4), .CNT_W(2))  if0 ();
  icache_refill_if #(.LINE_WORDS(4), .CNT_W(16)) if1 ();

  icache_refill_ctrl #(
    .LINE_WORDS(4), .MEM_LATENCY(1), .CNT_W(2)
  ) u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

  icache_refill_ctrl #(
    .LINE_WORDS(4), .MEM_LATENCY(3), .CNT_W(16)
  ) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  assign if0.pc         = pc;
  assign if0.miss_cache = miss;
  assign if0.mem_rdata  = memfn(if0.mem_addr);
  assign if1.pc         = pc;
  assign if1.miss_cache = miss;
  assign if1.mem_rdata  = memfn(if1.mem_addr);

  logic [31:0] o_addr [2];
  logic [31:0] o_data [2];
  logic [31:0] o_base [2];
  logic        o_we   [2];
  logic        o_done [2];
  logic        o_stall[2];
  logic [1:0]  o_idx  [2];
  logic [15:0] o_cnt  [2];

  assign o_addr[0]  = if0.mem_addr;
  assign o_data[0]  = if0.refill_data;
  assign o_base[0]  = if0.refill_base;
  assign o_we[0]    = if0.refill_we;
  assign o_done[0]  = if0.refill_done;
  assign o_stall[0] = if0.stall;
  assign o_idx[0]   = if0.refill_idx;
  assign o_cnt[0]   = 16'(if0.refill_count);
  assign o_addr[1]  = if1.mem_addr;
  assign o_data[1]  = if1.refill_data;
  assign o_base[1]  = if1.refill_base;
  assign o_we[1]    = if1.refill_we;
  assign o_done[1]  = if1.refill_done;
  assign o_stall[1] = if1.stall;
  assign o_idx[1]   = if1.refill_idx;
  assign o_cnt[1]   = 16'(if1.refill_count);

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] data;
    bit          done;
  } wr_t;

  wr_t         sbq [2][$];
  int          lat [2] = '{1, 3};
  int          cmax[2] = '{3, 65535};
  int          free_at[2] = '{0, 0};
  int          start[2] = '{0, 0};
  bit          active[2] = '{0, 0};
  logic [31:0] base_m[2] = '{32'd0, 32'd0};
  int          cnt_m[2] = '{0, 0};
  bit          armed = 1'b0;
  bit          rst_seen = 1'b0;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h want %h",
               nm, k, cyc, act, exp);
    end
  endtask

  // Line-level reference model: refill timing from latency arithmetic
  always @(negedge clk) begin : model
    int          c;
    bit          busy;
    logic [31:0] ea;
    wr_t         t;
    #1;
    c = cyc;
    if (rst_seen) armed = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (active[k] && c == free_at[k]) begin
        if (cnt_m[k] < cmax[k]) cnt_m[k]++;
        active[k] = 1'b0;
      end
      busy = (c < free_at[k]);
      if (armed) begin
        if (!busy)
          ea = pc;
        else if (c == free_at[k] - 1)
          ea = base_m[k];
        else
          ea = base_m[k] + 32'(4 * ((c - start[k] - 1) / lat[k]));
        chk("stall", k, 32'(o_stall[k]), 32'(miss | busy));
        chk("mem_addr", k, o_addr[k], ea);
        chk("refill_base", k, o_base[k], base_m[k]);
        chk("refill_count", k, 32'(o_cnt[k]), 32'(cnt_m[k]));
      end
      if (reset) begin
        while (sbq[k].size() > 0 &&
               sbq[k][sbq[k].size()-1].cyc > c)
          t = sbq[k].pop_back();
        free_at[k] = c + 1;
        active[k]  = 1'b0;
        base_m[k]  = '0;
        cnt_m[k]   = 0;
      end else if (armed && !busy && miss) begin
        start[k]   = c;
        base_m[k]  = pc & ~32'hF;
        free_at[k] = c + 2 + 4 * lat[k];
        active[k]  = 1'b1;
        for (int w = 0; w < 4; w++) begin
          t.cyc  = c + 1 + (w + 1) * lat[k];
          t.idx  = w;
          t.data = memfn(base_m[k] + 32'(4 * w));
          t.done = (w == 3);
          sbq[k].push_back(t);
        end
      end
    end
    if (reset) rst_seen = 1'b1;
  end

  // Scoreboard monitor: pops an expected write whenever refill_we fires
  always @(negedge clk) begin : monitor
    wr_t e;
    #2;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        while (sbq[k].size() > 0 && sbq[k][0].cyc < cyc) begin
          e = sbq[k].pop_front();
          checks++;
          errors++;
          $display("FAIL missing_write dut%0d cyc %0d: got none want idx %0d at cyc %0d",
                   k, cyc, e.idx, e.cyc);
        end
        if (o_we[k] === 1'b1) begin
          if (sbq[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write dut%0d cyc %0d: got idx %0d want none",
                     k, cyc, o_idx[k]);
          end else begin
            e = sbq[k].pop_front();
            chk("write_cycle", k, 32'(cyc), 32'(e.cyc));
            chk("refill_idx", k, 32'(o_idx[k]), 32'(e.idx));
            chk("refill_data", k, o_data[k], e.data);
            chk("refill_done", k, 32'(o_done[k]), 32'(e.done));
          end
        end else begin
          chk("idle_done", k, 32'(o_done[k]), 32'd0);
        end
      end
    end
  end

  task automatic step(input logic [31:0] p, input logic m, input logic r);
    @(negedge clk);
    pc    = p;
    miss  = m;
    reset = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step($urandom, 1'b0, 1'b0);
  endtask

  initial begin
    step(32'h0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b1);
    idle(2);
    // single miss at 0x24
    step(32'h0000_0024, 1'b1, 1'b0);
    idle(16);
    // pc/miss churn while refilling
    step(32'h0000_0040, 1'b1, 1'b0);
    step(32'h0000_0100, 1'b0, 1'b0);
    step(32'h0000_0100, 1'b1, 1'b0);
    step(32'h0000_0100, 1'b0, 1'b0);
    idle(16);
    // reset two cycles after the miss
    step(32'h0000_0024, 1'b1, 1'b0);
    step(32'h0000_0024, 1'b0, 1'b0);
    step(32'h0000_0024, 1'b1, 1'b1);
    idle(4);
    // miss held high: back-to-back refills
    for (int i = 0; i < 40; i++) step(32'h0000_0080, 1'b1, 1'b0);
    idle(16);
    // top-of-memory line
    step(32'hFFFF_FFF4, 1'b1, 1'b0);
    idle(16);
    // random traffic with rare resets
    for (int i = 0; i < 600; i++)
      step($urandom, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 199) == 0));
    idle(20);
    @(negedge clk);
    #3;
    chk("queue_empty", 0, 32'(sbq[0].size()), 32'd0);
    chk("queue_empty", 1, 32'(sbq[1].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
